// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM/WB pipeline slice: control bundle,
// bubble encoding, default data-memory depth and datapath widths.
package mem_wb_stage_pkg;

  localparam int DMEM_DEPTH_DEFAULT = 64;
  localparam int DATA_W             = 32;
  localparam int REG_ADDR_W         = 5;

  typedef struct packed {
    logic branch;
    logic memRead;
    logic memWrite;
    logic memtoReg;
    logic regWrite;
  } ctrl_t;

  // A bubble carries no side effects: no branch, no memory access, no writeback.
  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    ctrl_t                 ctrl;
    logic                  zero;
    logic [DATA_W-1:0]     branchAddr;
    logic [DATA_W-1:0]     aluRes;
    logic [DATA_W-1:0]     rtData;
    logic [REG_ADDR_W-1:0] rd;
  } exMem_t;

  typedef struct packed {
    logic                  regWrite;
    logic                  memtoReg;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     aluRes;
    logic [DATA_W-1:0]     readData;
  } memWb_t;

endpackage

// File: rtl/mem_wb_stage_data_ram.sv
// Word-addressed data memory: one synchronous write port, one asynchronous
// read port. Contents are deliberately never reset.
module data_ram
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM and WB stages of a 5-stage pipeline: EX/MEM register with branch flush,
// data memory, MEM/WB register. Define MEM_FORWARD_EN to expose EX/MEM forwarding ports.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  Branch_ex,
  input  logic                  MemRead_ex,
  input  logic                  MemWrite_ex,
  input  logic                  MemtoReg_ex,
  input  logic                  RegWrite_ex,
  input  logic [DATA_W-1:0]     Branch_addr_ex,
  input  logic                  alu_zero_ex,
  input  logic [DATA_W-1:0]     alu_res_ex,
  input  logic [DATA_W-1:0]     RtData_ex,
  input  logic [REG_ADDR_W-1:0] RegWriteAddr_ex,
  output logic                  PCSrc_mem,
  output logic [DATA_W-1:0]     Branch_addr_mem,
  output logic                  RegWrite_wb,
  output logic [REG_ADDR_W-1:0] RegWriteAddr_wb,
  output logic [DATA_W-1:0]     RegWriteData_wb
`ifdef MEM_FORWARD_EN
  ,
  output logic                  Fwd_RegWrite_mem,
  output logic [REG_ADDR_W-1:0] Fwd_Addr_mem,
  output logic [DATA_W-1:0]     Fwd_Data_mem
`endif
);

  localparam int ADDR_W = $clog2(DMEM_DEPTH);

  exMem_t            r_exMem;
  memWb_t            r_memWb;
  logic              w_pcSrc;
  logic              w_memWe;
  logic              w_isLoad;
  logic [ADDR_W-1:0] w_wordIdx;
  logic [DATA_W-1:0] w_readData;

  assign w_pcSrc = r_exMem.ctrl.branch & r_exMem.zero;

  // A taken branch in MEM squashes the instruction entering from EX; under stall the flush waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exMem <= '0;
    end else if (!stall) begin
      if (w_pcSrc) begin
        r_exMem      <= '0;
        r_exMem.ctrl <= CTRL_BUBBLE;
      end else begin
        r_exMem.ctrl <= '{branch:   Branch_ex,
                          memRead:  MemRead_ex,
                          memWrite: MemWrite_ex,
                          memtoReg: MemtoReg_ex,
                          regWrite: RegWrite_ex};
        r_exMem.zero       <= alu_zero_ex;
        r_exMem.branchAddr <= Branch_addr_ex;
        r_exMem.aluRes     <= alu_res_ex;
        r_exMem.rtData     <= RtData_ex;
        r_exMem.rd         <= RegWriteAddr_ex;
      end
    end
  end

  assign w_wordIdx = r_exMem.aluRes[ADDR_W+1:2];
  assign w_memWe   = r_exMem.ctrl.memWrite & ~stall & ~reset;
  assign w_isLoad  = r_exMem.ctrl.memRead & ~r_exMem.ctrl.memWrite;

  data_ram #(
    .DEPTH  (DMEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_memWe),
    .i_waddr (w_wordIdx),
    .i_wdata (r_exMem.rtData),
    .i_raddr (w_wordIdx),
    .o_rdata (w_readData)
  );

  // Read data of a combined read/write access is dropped: it behaves as a plain store.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_memWb <= '0;
    end else if (!stall) begin
      r_memWb.regWrite <= r_exMem.ctrl.regWrite;
      r_memWb.memtoReg <= r_exMem.ctrl.memtoReg;
      r_memWb.rd       <= r_exMem.rd;
      r_memWb.aluRes   <= r_exMem.aluRes;
      r_memWb.readData <= w_isLoad ? w_readData : '0;
    end
  end

  assign PCSrc_mem       = w_pcSrc;
  assign Branch_addr_mem = r_exMem.branchAddr;
  assign RegWrite_wb     = r_memWb.regWrite & (r_memWb.rd != '0);
  assign RegWriteAddr_wb = r_memWb.rd;
  assign RegWriteData_wb = r_memWb.memtoReg ? r_memWb.readData : r_memWb.aluRes;

`ifdef MEM_FORWARD_EN
  assign Fwd_RegWrite_mem = r_exMem.ctrl.regWrite;
  assign Fwd_Addr_mem     = r_exMem.rd;
  assign Fwd_Data_mem     = r_exMem.aluRes;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, multi-cycle
// corner sequences, and randomized traffic against an instruction-level model.
module tb_mem_wb_stage;

  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        Branch_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, RegWrite_ex;
  logic [31:0] Branch_addr_ex;
  logic        alu_zero_ex;
  logic [31:0] alu_res_ex;
  logic [31:0] RtData_ex;
  logic [4:0]  RegWriteAddr_ex;
  logic        PCSrc_mem;
  logic [31:0] Branch_addr_mem;
  logic        RegWrite_wb;
  logic [4:0]  RegWriteAddr_wb;
  logic [31:0] RegWriteData_wb;

  int nChecks = 0;
  int nFails  = 0;

  mem_wb_stage #(.DMEM_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .Branch_ex       (Branch_ex),
    .MemRead_ex      (MemRead_ex),
    .MemWrite_ex     (MemWrite_ex),
    .MemtoReg_ex     (MemtoReg_ex),
    .RegWrite_ex     (RegWrite_ex),
    .Branch_addr_ex  (Branch_addr_ex),
    .alu_zero_ex     (alu_zero_ex),
    .alu_res_ex      (alu_res_ex),
    .RtData_ex       (RtData_ex),
    .RegWriteAddr_ex (RegWriteAddr_ex),
    .PCSrc_mem       (PCSrc_mem),
    .Branch_addr_mem (Branch_addr_mem),
    .RegWrite_wb     (RegWrite_wb),
    .RegWriteAddr_wb (RegWriteAddr_wb),
    .RegWriteData_wb (RegWriteData_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        branch, memRead, memWrite, memtoReg, regWrite, zero;
    logic [31:0] baddr, alu, rt;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        ePc;
    logic [31:0] eBaddr;
    logic        eRw;
    logic [4:0]  eRd;
    logic [31:0] eData;
  } vec_t;

  // Instruction builders
  function automatic instr_t mkNop();
    instr_t r;
    r.branch = 1'b0; r.memRead = 1'b0; r.memWrite = 1'b0;
    r.memtoReg = 1'b0; r.regWrite = 1'b0; r.zero = 1'b0;
    r.baddr = '0; r.alu = '0; r.rt = '0; r.rd = '0;
    return r;
  endfunction

  function automatic instr_t mkAlu(logic [4:0] rd, logic [31:0] val);
    instr_t r = mkNop();
    r.regWrite = 1'b1; r.rd = rd; r.alu = val;
    return r;
  endfunction

  function automatic instr_t mkSw(logic [31:0] addr, logic [31:0] data);
    instr_t r = mkNop();
    r.memWrite = 1'b1; r.alu = addr; r.rt = data;
    return r;
  endfunction

  function automatic instr_t mkLw(logic [4:0] rd, logic [31:0] addr);
    instr_t r = mkNop();
    r.memRead = 1'b1; r.memtoReg = 1'b1; r.regWrite = 1'b1; r.rd = rd; r.alu = addr;
    return r;
  endfunction

  function automatic instr_t mkBr(logic zero, logic [31:0] target);
    instr_t r = mkNop();
    r.branch = 1'b1; r.zero = zero; r.baddr = target;
    return r;
  endfunction

  function automatic instr_t mkRmw(logic [31:0] addr, logic [31:0] data);
    instr_t r = mkSw(addr, data);
    r.memRead = 1'b1;
    return r;
  endfunction

  function automatic instr_t randInstr();
    instr_t r;
    case ($urandom_range(0, 4))
      0:       r = mkAlu(5'($urandom_range(0, 31)), $urandom());
      1:       r = mkLw(5'($urandom_range(0, 31)), $urandom());
      2:       r = mkSw($urandom(), $urandom());
      3:       r = mkBr(1'($urandom_range(0, 1)), $urandom());
      default: r = mkRmw($urandom(), $urandom());
    endcase
    r.rd = 5'($urandom_range(0, 31));
    return r;
  endfunction

  function automatic vec_t mkVec(instr_t in, logic ePc, logic [31:0] eBaddr,
                                 logic eRw, logic [4:0] eRd, logic [31:0] eData);
    vec_t v;
    v.in = in; v.ePc = ePc; v.eBaddr = eBaddr; v.eRw = eRw; v.eRd = eRd; v.eData = eData;
    return v;
  endfunction

  // Reference model: the instruction sitting in MEM, the resolved writeback, and memory.
  instr_t      mMem;
  logic        mWbRw;
  logic [4:0]  mWbRd;
  logic [31:0] mWbData;
  logic [31:0] dm [DEPTH];

  function automatic int idxOf(logic [31:0] a);
    return int'((a / 32'd4) % 32'(DEPTH));
  endfunction

  task automatic modelEdge(input instr_t in, input logic st, input logic rst);
    int w;
    if (rst) begin
      mMem = mkNop(); mWbRw = 1'b0; mWbRd = '0; mWbData = '0;
    end else if (!st) begin
      w       = idxOf(mMem.alu);
      mWbRw   = mMem.regWrite && (mMem.rd != 0);
      mWbRd   = mMem.rd;
      mWbData = !mMem.memtoReg ? mMem.alu :
                (mMem.memRead && !mMem.memWrite) ? dm[w] : 32'h0;
      if (mMem.memWrite) dm[w] = mMem.rt;
      mMem = (mMem.branch && mMem.zero) ? mkNop() : in;
    end
  endtask

  task automatic applyStimulus(input instr_t in, input logic st, input logic rst);
    Branch_ex = in.branch; MemRead_ex = in.memRead; MemWrite_ex = in.memWrite;
    MemtoReg_ex = in.memtoReg; RegWrite_ex = in.regWrite; alu_zero_ex = in.zero;
    Branch_addr_ex = in.baddr; alu_res_ex = in.alu; RtData_ex = in.rt;
    RegWriteAddr_ex = in.rd; stall = st; reset = rst;
    @(posedge clk);
    modelEdge(in, st, rst);
    #1;
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ePc, input logic [31:0] eBaddr,
                             input logic eRw, input logic [4:0] eRd, input logic [31:0] eData);
    check1({tag, ".PCSrc_mem"},       32'(PCSrc_mem),       32'(ePc));
    check1({tag, ".Branch_addr_mem"}, Branch_addr_mem,      eBaddr);
    check1({tag, ".RegWrite_wb"},     32'(RegWrite_wb),     32'(eRw));
    check1({tag, ".RegWriteAddr_wb"}, 32'(RegWriteAddr_wb), 32'(eRd));
    check1({tag, ".RegWriteData_wb"}, RegWriteData_wb,      eData);
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, mMem.branch && mMem.zero, mMem.baddr, mWbRw, mWbRd, mWbData);
  endtask

  vec_t        vecs [15];
  logic [31:0] oldWord;

  initial begin
    $display("[TB] start");
    mMem = mkNop(); mWbRw = 1'b0; mWbRd = '0; mWbData = '0;

    applyStimulus(mkNop(), 1'b0, 1'b1);
    applyStimulus(mkNop(), 1'b1, 1'b1);
    checkOutput("reset", 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Give every memory word a known value before anything reads it.
    for (int i = 0; i < DEPTH; i++) applyStimulus(mkSw(32'(i * 4), $urandom()), 1'b0, 1'b0);
    applyStimulus(mkNop(), 1'b0, 1'b0);
    applyStimulus(mkNop(), 1'b0, 1'b0);
    checkModel("init");

    // Directed vectors: outputs observed after the edge that consumes each row.
    vecs[0]  = mkVec(mkSw(32'h10, 32'hDEADBEEF), 1'b0, 32'h0,  1'b0, 5'd0,  32'h0);
    vecs[1]  = mkVec(mkLw(5'd3, 32'h10),         1'b0, 32'h0,  1'b0, 5'd0,  32'h10);
    vecs[2]  = mkVec(mkNop(),                    1'b0, 32'h0,  1'b1, 5'd3,  32'hDEADBEEF);
    vecs[3]  = mkVec(mkBr(1'b1, 32'h40),         1'b1, 32'h40, 1'b0, 5'd0,  32'h0);
    vecs[4]  = mkVec(mkAlu(5'd5, 32'h55),        1'b0, 32'h0,  1'b0, 5'd0,  32'h0);
    vecs[5]  = mkVec(mkNop(),                    1'b0, 32'h0,  1'b0, 5'd0,  32'h0);
    vecs[6]  = mkVec(mkBr(1'b0, 32'h80),         1'b0, 32'h80, 1'b0, 5'd0,  32'h0);
    vecs[7]  = mkVec(mkAlu(5'd7, 32'h77),        1'b0, 32'h0,  1'b0, 5'd0,  32'h0);
    vecs[8]  = mkVec(mkSw(32'h100, 32'h1),       1'b0, 32'h0,  1'b1, 5'd7,  32'h77);
    vecs[9]  = mkVec(mkLw(5'd9, 32'h0),          1'b0, 32'h0,  1'b0, 5'd0,  32'h100);
    vecs[10] = mkVec(mkAlu(5'd0, 32'h1234),      1'b0, 32'h0,  1'b1, 5'd9,  32'h1);
    vecs[11] = mkVec(mkNop(),                    1'b0, 32'h0,  1'b0, 5'd0,  32'h1234);
    vecs[12] = mkVec(mkRmw(32'h20, 32'hA5A5A5A5),1'b0, 32'h0,  1'b0, 5'd0,  32'h0);
    vecs[13] = mkVec(mkLw(5'd12, 32'h20),        1'b0, 32'h0,  1'b0, 5'd0,  32'h20);
    vecs[14] = mkVec(mkNop(),                    1'b0, 32'h0,  1'b1, 5'd12, 32'hA5A5A5A5);
    for (int k = 0; k < 15; k++) begin
      applyStimulus(vecs[k].in, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d", k), vecs[k].ePc, vecs[k].eBaddr,
                  vecs[k].eRw, vecs[k].eRd, vecs[k].eData);
    end

    // Store held in MEM by a 3-cycle stall: written once, on the releasing edge.
    oldWord = dm[17];
    applyStimulus(mkSw(32'h44, 32'hCAFE0001), 1'b0, 1'b0);
    checkModel("stallEnter");
    for (int s = 0; s < 3; s++) begin
      applyStimulus(mkLw(5'd4, 32'h44), 1'b1, 1'b0);
      checkModel($sformatf("stall%0d", s));
      check1($sformatf("stallMem%0d", s), dut.u_ram.r_mem[17], oldWord);
    end
    applyStimulus(mkLw(5'd4, 32'h44), 1'b0, 1'b0);
    check1("stallMemWritten", dut.u_ram.r_mem[17], 32'hCAFE0001);
    applyStimulus(mkNop(), 1'b0, 1'b0);
    checkOutput("stallLoad", 1'b0, 32'h0, 1'b1, 5'd4, 32'hCAFE0001);

    // Taken branch under stall: the flush waits for the first unstalled edge.
    applyStimulus(mkBr(1'b1, 32'h1C0), 1'b0, 1'b0);
    checkOutput("brStall0", 1'b1, 32'h1C0, 1'b0, 5'd0, 32'h0);
    for (int s = 0; s < 2; s++) begin
      applyStimulus(mkAlu(5'd6, 32'h66), 1'b1, 1'b0);
      checkOutput($sformatf("brStall%0d", s + 1), 1'b1, 32'h1C0, 1'b0, 5'd0, 32'h0);
    end
    applyStimulus(mkAlu(5'd6, 32'h66), 1'b0, 1'b0);
    checkOutput("brFlush", 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    applyStimulus(mkNop(), 1'b0, 1'b0);
    checkOutput("brBubbleWb", 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset in the store's MEM cycle suppresses the write.
    oldWord = dm[18];
    applyStimulus(mkSw(32'h48, 32'h0BADF00D), 1'b0, 1'b0);
    applyStimulus(mkLw(5'd8, 32'h48), 1'b0, 1'b1);
    checkOutput("rstStore", 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    check1("rstStoreMem", dut.u_ram.r_mem[18], oldWord);
    applyStimulus(mkLw(5'd8, 32'h48), 1'b0, 1'b0);
    applyStimulus(mkNop(), 1'b0, 1'b0);
    checkOutput("rstStoreLoad", 1'b0, 32'h0, 1'b1, 5'd8, oldWord);

    // Randomized traffic with occasional stalls and resets.
    for (int c = 0; c < 800; c++) begin
      applyStimulus(randInstr(), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 79) == 0));
      checkModel("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: DMEM_DEPTH, 64, data memory depth in 32-bit words; power of two; ADDR_W = log2(DMEM_DEPTH).
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  hold both pipeline registers this cycle.
REQ-005 Branch_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, RegWrite_ex  in  1 each  control bits of the instruction in EX.
REQ-006 Branch_addr_ex  in  32  branch target from EX.
REQ-007 alu_zero_ex  in  1  ALU zero flag.
REQ-008 alu_res_ex  in  32  ALU result; memory byte address for load/store.
REQ-009 RtData_ex  in  32  store data.
REQ-010 RegWriteAddr_ex  in  5  destination register.
REQ-011 PCSrc_mem  out  1  branch taken, resolved in MEM.
REQ-012 Branch_addr_mem  out  32  registered branch target.
REQ-013 RegWrite_wb  out  1  register-file write enable.
REQ-014 RegWriteAddr_wb  out  5  register-file write address.
REQ-015 RegWriteData_wb  out  32  register-file write data.

Function
REQ-016 The block SHALL contain an EX/MEM register capturing all REQ-005..010 inputs on each rising edge when not stalled, not flushed and not in reset.
REQ-017 PCSrc_mem SHALL equal Branch_mem AND zero_mem, combinationally from the EX/MEM register; Branch_addr_mem SHALL be the registered target.
REQ-018 Flush: when PCSrc_mem=1 at an edge with stall=0, the EX/MEM register SHALL load a bubble (all control bits 0, data fields 0) instead of the EX inputs.
REQ-019 Data memory: word index = alu_res_mem[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 ignored, so addresses wrap modulo DMEM_DEPTH*4.
REQ-020 Store SHALL write RtData_mem at the edge ending the MEM cycle when MemWrite_mem=1 and stall=0; never written while stalled.
REQ-021 Load read SHALL be combinational; a load from the word stored in the immediately preceding MEM cycle returns the new data.
REQ-022 MEM/WB register SHALL capture RegWrite, MemtoReg, RegWriteAddr, alu_res and read data at each unstalled edge.
REQ-023 RegWriteData_wb SHALL be read data when MemtoReg_wb=1, otherwise alu_res_wb.
REQ-024 RegWrite_wb SHALL be forced 0 when RegWriteAddr_wb=0.
REQ-025 Latency: instruction in EX in cycle N -> PCSrc_mem valid in N+1 -> writeback outputs valid in N+2.
REQ-026 stall=1 SHALL hold both registers and all outputs; stall with PCSrc_mem=1 SHALL defer the flush until the first unstalled edge.
REQ-027 MemRead_ex=1 with MemWrite_ex=1 SHALL be treated as a store; the read data is unused.

Reset
REQ-028 reset SHALL have priority over stall and flush and SHALL clear both registers, so all outputs read 0 the cycle after reset.
REQ-029 Data memory contents SHALL NOT be cleared by reset; reset mid-store SHALL suppress that write.

Configuration
REQ-030 With MEM_FORWARD_EN defined, the block SHALL add outputs Fwd_RegWrite_mem (1), Fwd_Addr_mem (5) and Fwd_Data_mem (32), driven from the EX/MEM register with alu_res_mem as data, for the EX forwarding mux; without the macro these ports SHALL be absent.

Structure
REQ-031 Shared package SHALL hold the bubble control constant, the DMEM_DEPTH default and the data/register-address widths.
REQ-032 Data memory SHALL be a sub-module, data_ram: one synchronous write port and one asynchronous read port.

Verification
REQ-033 Store then load: sw 0xDEADBEEF to address 0x10, lw from 0x10 in the next instruction -> RegWriteData_wb = 0xDEADBEEF two cycles after the lw is in EX.
REQ-034 Branch: Branch_ex=1, alu_zero_ex=1, target 0x40 -> PCSrc_mem=1 and Branch_addr_mem=0x40 in N+1; the following EX instruction (RegWrite=1) never asserts RegWrite_wb.
REQ-035 Stall: assert stall for 3 cycles during a sw -> memory written exactly once; outputs constant throughout the stall.
REQ-036 Wrap: store 0x1 to address 0x100 with DMEM_DEPTH=64 -> load from 0x0 returns 0x1.
REQ-037 Reset during store: reset=1 in the sw's MEM cycle -> location unchanged and all outputs 0 the next cycle; write with RegWriteAddr=0 -> RegWrite_wb=0.
